fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction fetch and issue controller sitting between program memory and the `cpu` block. Reads 16-bit instructions from a word-addressed memory at an 8-bit program counter, loads each into the CPU instruction register, pulses start, and waits for the CPU's handshake to complete before advancing. Stops on a HALT opcode, supports run/pause, and flags a fault if the CPU never acknowledges.

## Interface
Parameters:
- `ADDR_W`, 8: program counter / memory address width (matches datapath PC)
- `DATA_W`, 16: instruction width
- `TIMEOUT`, 15: max cycles allowed in WAIT_LO or EXEC before fault

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (asserted at 0)
- `run`  in  1  level; 1 = keep fetching, 0 = pause at the next instruction boundary
- `go`  in  1  one-cycle pulse; restarts from HALTED or FAULT at pc=0
- `mem_rd_req`  out  1  read request, held until accepted
- `mem_addr`  out  ADDR_W  read address (= pc)
- `mem_rdata`  in  DATA_W  read data, valid with `mem_rd_valid`
- `mem_rd_valid`  in  1  read completion, any latency ≥1 cycle
- `cpu_in`  out  DATA_W  instruction to CPU, driven from the internal instr register
- `cpu_load`  out  1  CPU instruction-register load strobe
- `cpu_s`  out  1  CPU start strobe
- `cpu_w`  in  1  CPU waiting flag (1 = idle)
- `pc`  out  ADDR_W  current program counter
- `instr_count`  out  16  completed-instruction counter
- `halted`  out  1  HALT opcode reached
- `fault`  out  1  handshake timeout occurred

## Operation
- States: IDLE, FETCH, LOAD, START, WAIT_LO, EXEC, HALTED, FAULT.
- IDLE: if `run`=1 -> FETCH.
- FETCH: `mem_rd_req`=1, `mem_addr`=pc. On `mem_rd_valid`=1 capture `mem_rdata` into instr; if `mem_rdata[15:13]`==3'b111 -> HALTED, else -> LOAD.
- LOAD: `cpu_load`=1 for exactly one cycle -> START.
- START: `cpu_s`=1 for exactly one cycle -> WAIT_LO.
- WAIT_LO: wait for `cpu_w`=0 (CPU left its wait state) -> EXEC.
- EXEC: wait for `cpu_w`=1; then pc <= pc+1, instr_count <= instr_count+1, -> FETCH if `run`=1 else IDLE.
- HALTED: `halted`=1; pc unchanged. `go` -> pc=0, `halted`=0, -> IDLE. 
- FAULT: `fault`=1; `go` -> pc=0, `fault`=0, -> IDLE. instr_count retained across `go`.
- Timer: cleared on entry to WAIT_LO and EXEC; increments each cycle in them; reaching TIMEOUT while the awaited `cpu_w` level has not arrived -> FAULT.
- pc wraps 255 -> 0 silently. instr_count saturates at 16'hFFFF.
- `run` sampled only in IDLE and at EXEC exit; deasserting mid-instruction never aborts it.
- `go` ignored outside HALTED/FAULT.
- `mem_rd_valid` ignored outside FETCH.

## Timing
- All control outputs Moore-decoded from registered state; no combinational path from inputs to outputs.
- Reset values: state IDLE, pc 0, instr_count 0, instr 0, `cpu_in` 0, `mem_rd_req` 0, `mem_addr` 0, `cpu_load` 0, `cpu_s` 0, `halted` 0, `fault` 0.
- Reset asserted mid-operation: all outputs return to reset values immediately (async). The CPU is reset separately by the same reset.
- Minimum instruction period with 1-cycle memory and a 4-cycle CPU op: FETCH 1 + LOAD 1 + START 1 + WAIT_LO ≥1 + EXEC ≥1.
- `cpu_in` is stable from LOAD through EXEC.
- CPU `w` lags `s` by one cycle, so WAIT_LO always lasts ≥1 cycle.

## Structure
- Shared package `seq_pkg`: state enum `seq_state_t`, `HALT_OPCODE` = 3'b111, and the opcode field slice constants.
- One natural sub-module: `seq_timer` (clearable TIMEOUT counter with `expired` output). Everything else is in the top-level FSM.

## Test plan
- Memory holds MOV R0,#5 then HALT, 1-cycle latency, run=1 -> one cpu_load/cpu_s pair; pc=1; halted=1; instr_count=1.
- Memory latency of 3 cycles -> mem_rd_req held 3 cycles, mem_addr stable, no cpu_load until valid.
- CPU model never drops cpu_w -> fault=1 exactly TIMEOUT cycles after WAIT_LO entry; go -> pc=0, fault=0.
- run dropped during EXEC of instr at pc=4 -> instruction completes, pc=5, FSM in IDLE, no mem_rd_req; run=1 resumes at 5.
- Preload pc=255 with a non-HALT word at 255 -> after completion pc=0.
- Reset low during EXEC -> next cycle all outputs are at reset values; release -> fetch from 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM states and opcode decode constants.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StWaitLo,
        StExec,
        StHalted,
        StFault
    } seq_state_t;

    localparam logic [2:0]  HALT_OPCODE = 3'b111;
    localparam int unsigned OPCODE_MSB  = 15;
    localparam int unsigned OPCODE_LSB  = 13;

endpackage

// File: rtl/seq_timer.sv
// Clearable handshake watchdog; expired is high once the count has spent TIMEOUT cycles enabled.
module seq_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] count_q;

    // expired marks the last permitted cycle, so the caller leaves after exactly TIMEOUT cycles
    assign expired = (count_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches instructions from program memory, hands each to the CPU with load/start strobes and
// waits for the CPU handshake to complete before advancing the program counter.
module fetch_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              go,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rd_valid,
    output logic [DATA_W-1:0] cpu_in,
    output logic              cpu_load,
    output logic              cpu_s,
    input  logic              cpu_w,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              halted,
    output logic              fault
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic [15:0]       count_q;
    logic              mem_rd_req_q;
    logic              cpu_load_q;
    logic              cpu_s_q;
    logic              halted_q;
    logic              fault_q;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;
    logic is_halt;
    logic op_done;

    assign is_halt = (mem_rdata[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
    assign op_done = (state_q == StExec) && cpu_w;

    // Restart the watchdog on entry to each handshake phase
    assign timer_enable = (state_q == StWaitLo) || (state_q == StExec);
    assign timer_clear  = !timer_enable || ((state_q == StWaitLo) && !cpu_w);

    seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (mem_rd_valid) state_d = is_halt ? StHalted : StLoad;
            end
            StLoad:  state_d = StStart;
            StStart: state_d = StWaitLo;
            StWaitLo: begin
                if (!cpu_w) begin
                    state_d = StExec;
                end else if (timer_expired) begin
                    state_d = StFault;
                end
            end
            StExec: begin
                if (cpu_w) begin
                    state_d = run ? StFetch : StIdle;
                end else if (timer_expired) begin
                    state_d = StFault;
                end
            end
            StHalted, StFault: begin
                if (go) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes and flags are registered from the next state so they line up with state_q
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            instr_q      <= '0;
            count_q      <= '0;
            mem_rd_req_q <= 1'b0;
            cpu_load_q   <= 1'b0;
            cpu_s_q      <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q == StFetch) && mem_rd_valid) begin
                instr_q <= mem_rdata;
            end

            if (op_done) begin
                pc_q <= pc_q + 1'b1;
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end else if (((state_q == StHalted) || (state_q == StFault)) && go) begin
                pc_q <= '0;
            end

            mem_rd_req_q <= (state_d == StFetch);
            cpu_load_q   <= (state_d == StLoad);
            cpu_s_q      <= (state_d == StStart);
            halted_q     <= (state_d == StHalted);
            fault_q      <= (state_d == StFault);
        end
    end

    assign mem_rd_req  = mem_rd_req_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign cpu_in      = instr_q;
    assign cpu_load    = cpu_load_q;
    assign cpu_s       = cpu_s_q;
    assign instr_count = count_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

endmodule
